// File: rtl/adc_sample_packer.sv
// ADC capture stage for AD9054A-class converters: packs one or two samples per clock
// into AXI-Stream beats through a first-word-fall-through beat FIFO with drop accounting.
module adc_sample_packer #(
  parameter int SAMPLE_W         = 8,
  parameter int SAMPLES_PER_BEAT = 4,
  parameter int DUALMODE_ENABLE  = 1,
  parameter int FIFO_DEPTH       = 8,
  parameter int PKT_BEATS        = 16
) (
  input  logic                                 clkin,
  input  logic                                 rstn,
  input  logic                                 en,
  input  logic                                 clear_stats,
  input  logic [SAMPLE_W-1:0]                  da,
  input  logic [SAMPLE_W-1:0]                  db,
  output logic                                 ds,
  output logic                                 demux,
  output logic [SAMPLE_W*SAMPLES_PER_BEAT-1:0] m_axis_tdata,
  output logic                                 m_axis_tvalid,
  input  logic                                 m_axis_tready,
  output logic                                 m_axis_tlast,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]      fifo_level,
  output logic                                 overflow,
  output logic [15:0]                          drop_cnt
);

  localparam int BEAT_W = SAMPLE_W * SAMPLES_PER_BEAT;
  localparam int STEP   = (DUALMODE_ENABLE != 0) ? 2 : 1;
  localparam int IW     = (SAMPLES_PER_BEAT > 1) ? $clog2(SAMPLES_PER_BEAT) : 1;
  localparam int AW     = $clog2(FIFO_DEPTH);
  localparam int LW     = $clog2(FIFO_DEPTH + 1);
  localparam int PW     = (PKT_BEATS > 1) ? $clog2(PKT_BEATS) : 1;

  localparam logic [IW-1:0] IDX_LAST  = IW'(SAMPLES_PER_BEAT - STEP);
  localparam logic [PW-1:0] PKT_LAST  = PW'(PKT_BEATS - 1);
  localparam logic [LW-1:0] LEVEL_MAX = LW'(FIFO_DEPTH);

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  logic [1:0] rst_sync;
  logic       rst_n_int;

  always_ff @(posedge clkin or negedge rstn) begin
    if (!rstn) rst_sync <= 2'b00;
    else       rst_sync <= {rst_sync[0], 1'b1};
  end
  assign rst_n_int = rst_sync[1];

  assign demux = (DUALMODE_ENABLE == 0);

  always_ff @(posedge clkin or negedge rst_n_int) begin
    if (!rst_n_int)                 ds <= 1'b0;
    else if (DUALMODE_ENABLE != 0)  ds <= en ? ~ds : 1'b0;
  end

  // p0: capture samples straight into the pack buffer; vld_p0 flags a completed beat
  logic [SAMPLE_W-1:0] pack_p0 [SAMPLES_PER_BEAT];
  logic [IW-1:0]       idx_p0;
  logic                vld_p0;
  logic [BEAT_W-1:0]   beat_p0;

  always_ff @(posedge clkin or negedge rst_n_int) begin
    if (!rst_n_int) begin
      idx_p0 <= '0;
      vld_p0 <= 1'b0;
    end else if (!en) begin
      idx_p0 <= '0;
      vld_p0 <= 1'b0;
    end else begin
      vld_p0 <= (idx_p0 == IDX_LAST);
      idx_p0 <= (idx_p0 == IDX_LAST) ? '0 : idx_p0 + IW'(STEP);
    end
  end

  always_ff @(posedge clkin) begin
    if (en) begin
      pack_p0[idx_p0] <= da;
      if (DUALMODE_ENABLE != 0) pack_p0[idx_p0 | IW'(1)] <= db;
    end
  end

  always_comb begin
    beat_p0 = '0;
    for (int k = 0; k < SAMPLES_PER_BEAT; k++) beat_p0[k*SAMPLE_W +: SAMPLE_W] = pack_p0[k];
  end

  // p1: beat FIFO storage; tlast is decided at write time so drops never disturb the cadence
  logic [BEAT_W-1:0] mem_data [FIFO_DEPTH];
  logic              mem_last [FIFO_DEPTH];
  logic [AW-1:0]     wr_ptr, rd_ptr;
  logic [LW-1:0]     mem_cnt;
  logic [PW-1:0]     pkt_cnt;
  logic              vld_p2, last_p2;
  logic [BEAT_W-1:0] data_p2;
  logic              pop, load, accept, wr, drop, last_in;

  assign pop     = vld_p2 && m_axis_tready;
  assign load    = (mem_cnt != '0) && (!vld_p2 || m_axis_tready);
  assign accept  = (fifo_level < LEVEL_MAX) || pop;
  assign wr      = vld_p0 && accept;
  assign drop    = vld_p0 && !accept;
  assign last_in = (pkt_cnt == PKT_LAST);

  always_ff @(posedge clkin) begin
    if (wr) begin
      mem_data[wr_ptr] <= beat_p0;
      mem_last[wr_ptr] <= last_in;
    end
  end

  always_ff @(posedge clkin or negedge rst_n_int) begin
    if (!rst_n_int) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      mem_cnt <= '0;
      pkt_cnt <= '0;
    end else begin
      if (wr)   wr_ptr <= wr_ptr + AW'(1);
      if (load) rd_ptr <= rd_ptr + AW'(1);
      mem_cnt <= mem_cnt + LW'(wr) - LW'(load);
      if (wr)   pkt_cnt <= last_in ? '0 : pkt_cnt + PW'(1);
    end
  end

  // p2: output register, counted in fifo_level; only reloads when empty or handshaking
  always_ff @(posedge clkin or negedge rst_n_int) begin
    if (!rst_n_int) begin
      vld_p2  <= 1'b0;
      data_p2 <= '0;
      last_p2 <= 1'b0;
    end else if (load) begin
      vld_p2  <= 1'b1;
      data_p2 <= mem_data[rd_ptr];
      last_p2 <= mem_last[rd_ptr];
    end else if (pop) begin
      vld_p2  <= 1'b0;
    end
  end

  always_ff @(posedge clkin or negedge rst_n_int) begin
    if (!rst_n_int) begin
      overflow <= 1'b0;
      drop_cnt <= '0;
    end else if (drop) begin
      overflow <= 1'b1;
      drop_cnt <= clear_stats ? 16'd1 : sat_inc16(drop_cnt);
    end else if (clear_stats) begin
      overflow <= 1'b0;
      drop_cnt <= '0;
    end
  end

  assign fifo_level    = mem_cnt + LW'(vld_p2);
  assign m_axis_tvalid = vld_p2;
  assign m_axis_tdata  = data_p2;
  assign m_axis_tlast  = last_p2;

endmodule

// File: tb/tb_adc_sample_packer.sv
// Directed bench for adc_sample_packer: a single-mode instance driven from a vector table
// and a dual-mode instance exercised by hand-written multi-cycle sequences.
module tb_adc_sample_packer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rstn;
  int          checks = 0;
  int          errors = 0;

  logic        s_en, s_clear, s_rdy, s_ds, s_demux, s_vld, s_last, s_ovf;
  logic [7:0]  s_da, s_db;
  logic [31:0] s_data;
  logic [3:0]  s_level;
  logic [15:0] s_drops;

  logic        d_en, d_clear, d_rdy, d_ds, d_demux, d_vld, d_last, d_ovf;
  logic [7:0]  d_da, d_db;
  logic [31:0] d_data;
  logic [3:0]  d_level;
  logic [15:0] d_drops;

  adc_sample_packer #(.SAMPLE_W(8), .SAMPLES_PER_BEAT(4), .DUALMODE_ENABLE(0),
                      .FIFO_DEPTH(8), .PKT_BEATS(16)) dut_s (
    .clkin(clk), .rstn(rstn), .en(s_en), .clear_stats(s_clear), .da(s_da), .db(s_db),
    .ds(s_ds), .demux(s_demux), .m_axis_tdata(s_data), .m_axis_tvalid(s_vld),
    .m_axis_tready(s_rdy), .m_axis_tlast(s_last), .fifo_level(s_level),
    .overflow(s_ovf), .drop_cnt(s_drops));

  adc_sample_packer #(.SAMPLE_W(8), .SAMPLES_PER_BEAT(4), .DUALMODE_ENABLE(1),
                      .FIFO_DEPTH(8), .PKT_BEATS(4)) dut_d (
    .clkin(clk), .rstn(rstn), .en(d_en), .clear_stats(d_clear), .da(d_da), .db(d_db),
    .ds(d_ds), .demux(d_demux), .m_axis_tdata(d_data), .m_axis_tvalid(d_vld),
    .m_axis_tready(d_rdy), .m_axis_tlast(d_last), .fifo_level(d_level),
    .overflow(d_ovf), .drop_cnt(d_drops));

  typedef struct packed {
    logic        en;
    logic [7:0]  da;
    logic        rdy;
    logic        vld;
    logic [31:0] data;
    logic [3:0]  level;
  } vec_t;

  vec_t tbl [19];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    rstn = 1'b0;
    s_en = 1'b0; s_da = '0; s_db = '0; s_clear = 1'b0; s_rdy = 1'b0;
    d_en = 1'b0; d_da = '0; d_db = '0; d_clear = 1'b0; d_rdy = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk) rstn = 1'b1;
    repeat (4) @(negedge clk);
  endtask

  task automatic d_cycle(input logic e, input logic [7:0] a, input logic [7:0] b);
    d_en = e; d_da = a; d_db = b;
    @(posedge clk);
    @(negedge clk);
  endtask

  function automatic logic [31:0] exp_beat(input logic [7:0] base, input int bj);
    logic [7:0] b;
    b = base + 8'(4 * bj);
    return {b + 8'd3, b + 8'd2, b + 8'd1, b};
  endfunction

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    logic [7:0] sv;
    logic [7:0] base;
    int acc;

    tbl[0]  = '{1'b1, 8'h01, 1'b1, 1'b0, 32'h0,        4'd0};
    tbl[1]  = '{1'b1, 8'h02, 1'b1, 1'b0, 32'h0,        4'd0};
    tbl[2]  = '{1'b1, 8'h03, 1'b1, 1'b0, 32'h0,        4'd0};
    tbl[3]  = '{1'b1, 8'h04, 1'b1, 1'b0, 32'h0,        4'd0};
    tbl[4]  = '{1'b1, 8'h05, 1'b1, 1'b0, 32'h0,        4'd1};
    tbl[5]  = '{1'b1, 8'h06, 1'b1, 1'b1, 32'h04030201, 4'd1};
    tbl[6]  = '{1'b1, 8'h07, 1'b1, 1'b0, 32'h0,        4'd0};
    tbl[7]  = '{1'b1, 8'h08, 1'b1, 1'b0, 32'h0,        4'd0};
    tbl[8]  = '{1'b1, 8'h09, 1'b1, 1'b0, 32'h0,        4'd1};
    tbl[9]  = '{1'b1, 8'h0A, 1'b1, 1'b1, 32'h08070605, 4'd1};
    tbl[10] = '{1'b0, 8'h0B, 1'b1, 1'b0, 32'h0,        4'd0};
    tbl[11] = '{1'b1, 8'h21, 1'b1, 1'b0, 32'h0,        4'd0};
    tbl[12] = '{1'b1, 8'h22, 1'b1, 1'b0, 32'h0,        4'd0};
    tbl[13] = '{1'b1, 8'h23, 1'b1, 1'b0, 32'h0,        4'd0};
    tbl[14] = '{1'b1, 8'h24, 1'b1, 1'b0, 32'h0,        4'd0};
    tbl[15] = '{1'b0, 8'h00, 1'b1, 1'b0, 32'h0,        4'd1};
    tbl[16] = '{1'b0, 8'h00, 1'b0, 1'b1, 32'h24232221, 4'd1};
    tbl[17] = '{1'b0, 8'h00, 1'b0, 1'b1, 32'h24232221, 4'd1};
    tbl[18] = '{1'b0, 8'h00, 1'b1, 1'b0, 32'h0,        4'd0};

    do_reset();

    chk("rst_s_tvalid", 32'(s_vld), 32'd0);
    chk("rst_s_tdata", s_data, 32'd0);
    chk("rst_s_level", 32'(s_level), 32'd0);
    chk("s_demux", 32'(s_demux), 32'd1);
    chk("rst_d_tvalid", 32'(d_vld), 32'd0);
    chk("rst_d_tlast", 32'(d_last), 32'd0);
    chk("rst_d_ovf", 32'(d_ovf), 32'd0);
    chk("rst_d_drops", 32'(d_drops), 32'd0);
    chk("rst_d_ds", 32'(d_ds), 32'd0);
    chk("d_demux", 32'(d_demux), 32'd0);

    for (int i = 0; i < 19; i++) begin
      s_en = tbl[i].en; s_da = tbl[i].da; s_rdy = tbl[i].rdy;
      @(posedge clk);
      @(negedge clk);
      chk($sformatf("s_tvalid[%0d]", i), 32'(s_vld), 32'(tbl[i].vld));
      chk($sformatf("s_level[%0d]", i), 32'(s_level), 32'(tbl[i].level));
      chk($sformatf("s_ds[%0d]", i), 32'(s_ds), 32'd0);
      if (tbl[i].vld) chk($sformatf("s_tdata[%0d]", i), s_data, tbl[i].data);
    end

    d_rdy = 1'b1;
    d_cycle(1'b1, 8'h11, 8'h22);
    chk("a_ds1", 32'(d_ds), 32'd1);
    d_cycle(1'b1, 8'h33, 8'h44);
    chk("a_ds2", 32'(d_ds), 32'd0);
    d_cycle(1'b1, 8'h55, 8'h66);
    chk("a_ds3", 32'(d_ds), 32'd1);
    chk("a_vld_n1", 32'(d_vld), 32'd0);
    chk("a_level_n1", 32'(d_level), 32'd1);
    d_cycle(1'b0, 8'h00, 8'h00);
    chk("a_ds_off", 32'(d_ds), 32'd0);
    chk("a_vld_n2", 32'(d_vld), 32'd1);
    chk("a_tdata", d_data, 32'h44332211);
    chk("a_tlast", 32'(d_last), 32'd0);
    d_cycle(1'b0, 8'h00, 8'h00);
    chk("a_vld_pop", 32'(d_vld), 32'd0);

    do_reset();
    base = 8'h40;
    sv = base;
    for (int c = 0; c < 18; c++) begin
      d_cycle(1'b1, sv, sv + 8'd1);
      sv = sv + 8'd2;
    end
    chk("b_level_full", 32'(d_level), 32'd8);
    chk("b_drops_before", 32'(d_drops), 32'd0);
    d_cycle(1'b0, 8'h00, 8'h00);
    chk("b_drops", 32'(d_drops), 32'd1);
    chk("b_ovf", 32'(d_ovf), 32'd1);
    chk("b_level_hold", 32'(d_level), 32'd8);
    chk("b_tdata_hold", d_data, exp_beat(base, 0));
    for (int c = 0; c < 2; c++) begin
      d_cycle(1'b1, sv, sv + 8'd1);
      sv = sv + 8'd2;
    end
    d_clear = 1'b1;
    d_cycle(1'b0, 8'h00, 8'h00);
    chk("b_clr_drop_cnt", 32'(d_drops), 32'd1);
    chk("b_clr_drop_ovf", 32'(d_ovf), 32'd1);
    d_cycle(1'b0, 8'h00, 8'h00);
    d_clear = 1'b0;
    chk("b_clr_cnt", 32'(d_drops), 32'd0);
    chk("b_clr_ovf", 32'(d_ovf), 32'd0);

    acc = 0;
    for (int c = 0; c < 80 && acc < 12; c++) begin
      if (d_vld) begin
        chk($sformatf("b_tdata[%0d]", acc), d_data, exp_beat(base, (acc < 8) ? acc : acc + 2));
        chk($sformatf("b_tlast[%0d]", acc), 32'(d_last), 32'((acc % 4) == 3));
        acc++;
      end
      d_rdy = 1'b1;
      if (c < 16) begin
        d_en = 1'b1; d_da = sv; d_db = sv + 8'd1;
        sv = sv + 8'd2;
      end else begin
        d_en = 1'b0;
      end
      @(posedge clk);
      @(negedge clk);
    end
    chk("b_drain_count", 32'(acc), 32'd12);
    chk("b_no_new_drops", 32'(d_drops), 32'd0);

    do_reset();
    sv = 8'h80;
    for (int c = 0; c < 7; c++) begin
      d_cycle(1'b1, sv, sv + 8'd1);
      sv = sv + 8'd2;
    end
    chk("d_level_3", 32'(d_level), 32'd3);
    chk("d_vld_pre", 32'(d_vld), 32'd1);
    d_en = 1'b0;
    rstn = 1'b0;
    #1;
    chk("d_rst_vld", 32'(d_vld), 32'd0);
    chk("d_rst_level", 32'(d_level), 32'd0);
    chk("d_rst_tdata", d_data, 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk) rstn = 1'b1;
    repeat (4) @(negedge clk);
    chk("d_post_level", 32'(d_level), 32'd0);
    chk("d_post_vld", 32'(d_vld), 32'd0);
    d_rdy = 1'b1;
    d_cycle(1'b1, 8'hA1, 8'hB1);
    d_cycle(1'b1, 8'hA2, 8'hB2);
    d_cycle(1'b0, 8'h00, 8'h00);
    d_cycle(1'b0, 8'h00, 8'h00);
    chk("d_resume_vld", 32'(d_vld), 32'd1);
    chk("d_resume_tdata", d_data, 32'hB2A2B1A1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
